// File: rtl/rtc_apb_regs.sv
// rtc_apb_regs - APB3 register block for a BCD real-time clock.
//
// Purpose: gives software access to the RTC time-keeper. Register writes
// are forwarded to the time-keeper as "set" values with one-cycle update
// strobes. Live time and timer value are read back. Alarm/timer events and
// midnight rollovers are latched in a W1C status register that can raise
// a maskable level interrupt.
//
// Register map (decoded on paddr_i[4:2]):
//   0 CLOCK    RW  [21:0] BCD hh:mm:ss (read returns live clock_i)
//   1 SEC_INIT RW  [9:0]
//   2 ALARM    RW  [21:0] time, [31] enable (read time comes from alarm_clock_i)
//   3 TIMER    RW  [16:0] target, [30] retrig, [31] enable
//   4 TVAL     RO  timer_value_i
//   5 STATUS   W1C [0] event pending, [1] day pending
//   6 IRQ_MASK RW  [1:0]
//   7 DAYCNT   RO  day counter (only when RTC_DAY_COUNTER_EN is defined, else 0)
//
// Bus timing: writes complete with zero wait states. Reads take one wait
// state and return registered data. Invalid BCD CLOCK/ALARM writes and
// writes to read-only registers complete with pslverr_o and no effect.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   paddr_i .. pslverr_o     APB3 slave
//   clock_*/alarm_*/timer_*  time-keeper set values and update strobes
//   init_sec_cnt_o           SEC_INIT value for the time-keeper prescaler
//   clock_i, alarm_clock_i,
//   timer_value_i            time-keeper status for readback
//   event_i, update_day_i    event pulses latched into STATUS
//   irq_o                    registered OR of (STATUS & IRQ_MASK)
//
// Configuration macro: RTC_DAY_COUNTER_EN adds a 16-bit wrapping day
// counter that increments on update_day_i and is readable at DAYCNT.

module rtc_apb_regs #(
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  input  logic                      pwrite_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      clock_update_o,
  output logic [21:0]               clock_o,
  output logic [9:0]                init_sec_cnt_o,
  output logic                      alarm_update_o,
  output logic                      alarm_enable_o,
  output logic [21:0]               alarm_clock_o,
  output logic                      timer_update_o,
  output logic                      timer_enable_o,
  output logic                      timer_retrig_o,
  output logic [16:0]               timer_target_o,
  input  logic [21:0]               clock_i,
  input  logic [21:0]               alarm_clock_i,
  input  logic [16:0]               timer_value_i,
  input  logic                      event_i,
  input  logic                      update_day_i,
  output logic                      irq_o
);

  localparam logic [2:0] A_CLOCK    = 3'd0;
  localparam logic [2:0] A_SEC_INIT = 3'd1;
  localparam logic [2:0] A_ALARM    = 3'd2;
  localparam logic [2:0] A_TIMER    = 3'd3;
  localparam logic [2:0] A_TVAL     = 3'd4;
  localparam logic [2:0] A_STATUS   = 3'd5;
  localparam logic [2:0] A_IRQ_MASK = 3'd6;
  localparam logic [2:0] A_DAYCNT   = 3'd7;

  // One BCD byte: low digit must be a decimal digit and the whole value
  // must not exceed the field's maximum (0x59 for mm/ss, 0x23 for hh).
  function automatic logic bcd_byte_ok(input logic [7:0] b, input logic [7:0] max);
    return (b[3:0] <= 4'd9) && (b <= max);
  endfunction

  function automatic logic bcd_time_ok(input logic [21:0] t);
    logic [7:0] hh;
    hh = {2'b00, t[21:16]};
    return bcd_byte_ok(t[7:0], 8'h59) && bcd_byte_ok(t[15:8], 8'h59) &&
           bcd_byte_ok(hh, 8'h23);
  endfunction

  logic [21:0] clock_q, clock_d;
  logic [9:0]  sec_init_q, sec_init_d;
  logic [21:0] alarm_clock_q, alarm_clock_d;
  logic        alarm_en_q, alarm_en_d;
  logic [16:0] timer_target_q, timer_target_d;
  logic        timer_retrig_q, timer_retrig_d;
  logic        timer_en_q, timer_en_d;
  logic [1:0]  status_q, status_d;
  logic [1:0]  mask_q, mask_d;
  logic        irq_q, irq_d;
  logic        clk_upd_q, clk_upd_d;
  logic        alm_upd_q, alm_upd_d;
  logic        tmr_upd_q, tmr_upd_d;
  logic        rd_pend_q, rd_pend_d;
  logic [31:0] prdata_q, prdata_d;
  logic [15:0] daycnt_rd;

  logic [2:0]  addr;
  logic        wr_acc;
  logic        rd_first;
  logic        wr_err;
  logic [1:0]  status_clr;
  logic [31:0] rdata_mux;

  // Only paddr_i[4:2] and selected pwdata_i fields are meaningful.
  logic        unused_bits;
  assign unused_bits = ^{paddr_i, pwdata_i};

  assign addr     = paddr_i[4:2];
  assign wr_acc   = psel_i & penable_i & pwrite_i;
  // First access cycle of a read; the second cycle (rd_pend_q) completes it.
  assign rd_first = psel_i & penable_i & ~pwrite_i & ~rd_pend_q;

`ifdef RTC_DAY_COUNTER_EN
  logic [15:0] daycnt_q;

  // Cleared only by reset; wraps naturally at 16 bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      daycnt_q <= '0;
    end else if (update_day_i) begin
      daycnt_q <= daycnt_q + 16'd1;
    end
  end

  assign daycnt_rd = daycnt_q;
`else
  assign daycnt_rd = '0;
`endif

  always_comb begin
    clock_d        = clock_q;
    sec_init_d     = sec_init_q;
    alarm_clock_d  = alarm_clock_q;
    alarm_en_d     = alarm_en_q;
    timer_target_d = timer_target_q;
    timer_retrig_d = timer_retrig_q;
    timer_en_d     = timer_en_q;
    mask_d         = mask_q;
    clk_upd_d      = 1'b0;
    alm_upd_d      = 1'b0;
    tmr_upd_d      = 1'b0;
    wr_err         = 1'b0;
    status_clr     = 2'b00;

    if (wr_acc) begin
      case (addr)
        A_CLOCK: begin
          if (bcd_time_ok(pwdata_i[21:0])) begin
            clock_d   = pwdata_i[21:0];
            clk_upd_d = 1'b1;
          end else begin
            wr_err = 1'b1;
          end
        end
        A_SEC_INIT: sec_init_d = pwdata_i[9:0];
        A_ALARM: begin
          if (bcd_time_ok(pwdata_i[21:0])) begin
            alarm_clock_d = pwdata_i[21:0];
            alarm_en_d    = pwdata_i[31];
            alm_upd_d     = 1'b1;
          end else begin
            wr_err = 1'b1;
          end
        end
        A_TIMER: begin
          timer_target_d = pwdata_i[16:0];
          timer_retrig_d = pwdata_i[30];
          timer_en_d     = pwdata_i[31];
          tmr_upd_d      = 1'b1;
        end
        A_STATUS:   status_clr = pwdata_i[1:0];
        A_IRQ_MASK: mask_d     = pwdata_i[1:0];
        default:    wr_err     = 1'b1;  // TVAL, DAYCNT are read-only
      endcase
    end

    // Set is OR-ed in after the clear so a same-cycle event wins.
    status_d = (status_q & ~status_clr) | {update_day_i, event_i};
    irq_d    = |(status_q & mask_q);
  end

  always_comb begin
    rdata_mux = '0;
    case (addr)
      A_CLOCK:    rdata_mux = {10'b0, clock_i};
      A_SEC_INIT: rdata_mux = {22'b0, sec_init_q};
      A_ALARM:    rdata_mux = {alarm_en_q, 9'b0, alarm_clock_i};
      A_TIMER:    rdata_mux = {timer_en_q, timer_retrig_q, 13'b0, timer_target_q};
      A_TVAL:     rdata_mux = {15'b0, timer_value_i};
      A_STATUS:   rdata_mux = {30'b0, status_q};
      A_IRQ_MASK: rdata_mux = {30'b0, mask_q};
      A_DAYCNT:   rdata_mux = {16'b0, daycnt_rd};
      default:    rdata_mux = '0;
    endcase
    rd_pend_d = rd_first;
    prdata_d  = rd_first ? rdata_mux : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clock_q        <= '0;
      sec_init_q     <= '0;
      alarm_clock_q  <= '0;
      alarm_en_q     <= 1'b0;
      timer_target_q <= '0;
      timer_retrig_q <= 1'b0;
      timer_en_q     <= 1'b0;
      status_q       <= '0;
      mask_q         <= '0;
      irq_q          <= 1'b0;
      clk_upd_q      <= 1'b0;
      alm_upd_q      <= 1'b0;
      tmr_upd_q      <= 1'b0;
      rd_pend_q      <= 1'b0;
      prdata_q       <= '0;
    end else begin
      clock_q        <= clock_d;
      sec_init_q     <= sec_init_d;
      alarm_clock_q  <= alarm_clock_d;
      alarm_en_q     <= alarm_en_d;
      timer_target_q <= timer_target_d;
      timer_retrig_q <= timer_retrig_d;
      timer_en_q     <= timer_en_d;
      status_q       <= status_d;
      mask_q         <= mask_d;
      irq_q          <= irq_d;
      clk_upd_q      <= clk_upd_d;
      alm_upd_q      <= alm_upd_d;
      tmr_upd_q      <= tmr_upd_d;
      rd_pend_q      <= rd_pend_d;
      prdata_q       <= prdata_d;
    end
  end

  // Write response is combinational (zero wait); read response is the
  // registered second cycle. Reset suppresses any response in flight.
  assign pready_o  = ~rst_i & (wr_acc | rd_pend_q);
  assign pslverr_o = ~rst_i & wr_acc & wr_err;
  assign prdata_o  = rd_pend_q ? prdata_q : '0;

  assign clock_update_o = clk_upd_q;
  assign clock_o        = clock_q;
  assign init_sec_cnt_o = sec_init_q;
  assign alarm_update_o = alm_upd_q;
  assign alarm_enable_o = alarm_en_q;
  assign alarm_clock_o  = alarm_clock_q;
  assign timer_update_o = tmr_upd_q;
  assign timer_enable_o = timer_en_q;
  assign timer_retrig_o = timer_retrig_q;
  assign timer_target_o = timer_target_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_rtc_apb_regs.sv
// Directed testbench for rtc_apb_regs.
module tb_rtc_apb_regs;

  localparam logic [11:0] A_CLOCK = 12'h000, A_SEC = 12'h004, A_ALARM = 12'h008,
                          A_TIMER = 12'h00C, A_TVAL = 12'h010, A_STATUS = 12'h014,
                          A_MASK = 12'h018, A_DAYCNT = 12'h01C;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [11:0] paddr_i = '0;
  logic [31:0] pwdata_i = '0;
  logic        pwrite_i = 1'b0, psel_i = 1'b0, penable_i = 1'b0;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic        clock_update_o, alarm_update_o, alarm_enable_o;
  logic        timer_update_o, timer_enable_o, timer_retrig_o;
  logic [21:0] clock_o, alarm_clock_o;
  logic [9:0]  init_sec_cnt_o;
  logic [16:0] timer_target_o;
  logic [21:0] clock_i = '0, alarm_clock_i = '0;
  logic [16:0] timer_value_i = '0;
  logic        event_i = 1'b0, update_day_i = 1'b0;
  logic        irq_o;

  int checks = 0;
  int fails  = 0;

  logic        rdy, err, rdy0;
  logic [31:0] d0, d;
  bit          ok;

  rtc_apb_regs #(.APB_ADDR_WIDTH(12)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .pwrite_i(pwrite_i), .psel_i(psel_i), .penable_i(penable_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .clock_update_o(clock_update_o), .clock_o(clock_o), .init_sec_cnt_o(init_sec_cnt_o),
    .alarm_update_o(alarm_update_o), .alarm_enable_o(alarm_enable_o),
    .alarm_clock_o(alarm_clock_o), .timer_update_o(timer_update_o),
    .timer_enable_o(timer_enable_o), .timer_retrig_o(timer_retrig_o),
    .timer_target_o(timer_target_o), .clock_i(clock_i), .alarm_clock_i(alarm_clock_i),
    .timer_value_i(timer_value_i), .event_i(event_i), .update_day_i(update_day_i),
    .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // APB write; evt drives event_i during the access cycle.
  task automatic apb_write(input logic [11:0] a, input logic [31:0] wd, input logic evt,
                           output logic r, output logic e);
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = a; pwdata_i = wd;
    @(posedge clk_i); #1;
    penable_i = 1'b1; event_i = evt;
    @(negedge clk_i);
    r = pready_o; e = pslverr_o;
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; event_i = 1'b0;
  endtask

  // APB read; returns pready/prdata of the first access cycle and the final data.
  task automatic apb_read(input logic [11:0] a, output logic r0, output logic [31:0] pd0,
                          output logic [31:0] pd, output bit done);
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = a;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    @(negedge clk_i);
    r0 = pready_o; pd0 = prdata_o; done = 1'b0; pd = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (pready_o) begin pd = prdata_o; done = 1'b1; break; end
    end
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (pready_o !== 1'b0) begin fails++; $display("FAIL rst_pready: got %b want 0", pready_o); end
    checks++; if (pslverr_o !== 1'b0) begin fails++; $display("FAIL rst_pslverr: got %b want 0", pslverr_o); end
    checks++; if (prdata_o !== 32'h0) begin fails++; $display("FAIL rst_prdata: got %h want 0", prdata_o); end
    checks++; if (clock_o !== 22'h0) begin fails++; $display("FAIL rst_clock: got %h want 0", clock_o); end
    checks++; if (clock_update_o !== 1'b0) begin fails++; $display("FAIL rst_clkupd: got %b want 0", clock_update_o); end
    checks++; if (irq_o !== 1'b0) begin fails++; $display("FAIL rst_irq: got %b want 0", irq_o); end
    checks++; if (timer_target_o !== 17'h0) begin fails++; $display("FAIL rst_ttarget: got %h want 0", timer_target_o); end
    checks++; if (alarm_enable_o !== 1'b0) begin fails++; $display("FAIL rst_alen: got %b want 0", alarm_enable_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_clock_write();
    apb_write(A_SEC, 32'h0000_0155, 1'b0, rdy, err);
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL sec_err: got %b want 0", err); end
    apb_write(A_CLOCK, 32'h0023_5959, 1'b0, rdy, err);
    checks++; if (rdy !== 1'b1) begin fails++; $display("FAIL clk_wr_ready: got %b want 1", rdy); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL clk_wr_err: got %b want 0", err); end
    checks++; if (clock_update_o !== 1'b1) begin fails++; $display("FAIL clk_upd_pulse: got %b want 1", clock_update_o); end
    checks++; if (clock_o !== 22'h235959) begin fails++; $display("FAIL clk_val: got %h want 235959", clock_o); end
    checks++; if (init_sec_cnt_o !== 10'h155) begin fails++; $display("FAIL sec_init: got %h want 155", init_sec_cnt_o); end
    @(posedge clk_i); #1;
    checks++; if (clock_update_o !== 1'b0) begin fails++; $display("FAIL clk_upd_width: got %b want 0", clock_update_o); end
  endtask

  task automatic test_clock_bad();
    apb_write(A_CLOCK, 32'h0024_60AA, 1'b0, rdy, err);
    checks++; if (rdy !== 1'b1) begin fails++; $display("FAIL bad_clk_ready: got %b want 1", rdy); end
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL bad_clk_err: got %b want 1", err); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (clock_update_o !== 1'b0) begin fails++; $display("FAIL bad_clk_upd: got %b want 0", clock_update_o); end
      @(posedge clk_i); #1;
    end
    checks++; if (clock_o !== 22'h235959) begin fails++; $display("FAIL bad_clk_keep: got %h want 235959", clock_o); end
    // Hours 0x23 boundary accepted, minute 0x60 rejected
    apb_write(A_CLOCK, 32'h0023_6000, 1'b0, rdy, err);
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL bad_min60_err: got %b want 1", err); end
  endtask

  task automatic test_alarm();
    apb_write(A_ALARM, 32'h8012_3045, 1'b0, rdy, err);
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL alm_err: got %b want 0", err); end
    checks++; if (alarm_update_o !== 1'b1) begin fails++; $display("FAIL alm_upd: got %b want 1", alarm_update_o); end
    checks++; if (alarm_clock_o !== 22'h123045) begin fails++; $display("FAIL alm_val: got %h want 123045", alarm_clock_o); end
    checks++; if (alarm_enable_o !== 1'b1) begin fails++; $display("FAIL alm_en: got %b want 1", alarm_enable_o); end
    apb_write(A_ALARM, 32'h0012_0A00, 1'b0, rdy, err);
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL alm_bad_err: got %b want 1", err); end
    checks++; if (alarm_update_o !== 1'b0) begin fails++; $display("FAIL alm_bad_upd: got %b want 0", alarm_update_o); end
    checks++; if (alarm_clock_o !== 22'h123045) begin fails++; $display("FAIL alm_bad_keep: got %h want 123045", alarm_clock_o); end
  endtask

  task automatic test_timer_write();
    apb_write(A_TIMER, 32'hC001_5A5A, 1'b0, rdy, err);
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL tmr_err: got %b want 0", err); end
    checks++; if (timer_update_o !== 1'b1) begin fails++; $display("FAIL tmr_upd: got %b want 1", timer_update_o); end
    checks++; if (timer_target_o !== 17'h15A5A) begin fails++; $display("FAIL tmr_target: got %h want 15a5a", timer_target_o); end
    checks++; if (timer_retrig_o !== 1'b1) begin fails++; $display("FAIL tmr_retrig: got %b want 1", timer_retrig_o); end
    checks++; if (timer_enable_o !== 1'b1) begin fails++; $display("FAIL tmr_en: got %b want 1", timer_enable_o); end
    @(posedge clk_i); #1;
    checks++; if (timer_update_o !== 1'b0) begin fails++; $display("FAIL tmr_upd_width: got %b want 0", timer_update_o); end
  endtask

  task automatic test_reads();
    timer_value_i = 17'h1ABCD; clock_i = 22'h101010; alarm_clock_i = 22'h0A0B0C;
    apb_read(A_TVAL, rdy0, d0, d, ok);
    checks++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL tval_wait: got %b want 0", rdy0); end
    checks++; if (d0 !== 32'h0) begin fails++; $display("FAIL tval_wait_data: got %h want 0", d0); end
    checks++; if (!ok) begin fails++; $display("FAIL tval_timeout: got 0 want 1"); end
    checks++; if (d !== 32'h0001_ABCD) begin fails++; $display("FAIL tval_data: got %h want 0001abcd", d); end
    apb_read(A_CLOCK, rdy0, d0, d, ok);
    checks++; if (d !== 32'h0010_1010) begin fails++; $display("FAIL rd_clock: got %h want 00101010", d); end
    apb_read(A_ALARM, rdy0, d0, d, ok);
    checks++; if (d !== 32'h800A_0B0C) begin fails++; $display("FAIL rd_alarm: got %h want 800a0b0c", d); end
    apb_read(A_TIMER, rdy0, d0, d, ok);
    checks++; if (d !== 32'hC001_5A5A) begin fails++; $display("FAIL rd_timer: got %h want c0015a5a", d); end
    apb_read(A_SEC, rdy0, d0, d, ok);
    checks++; if (d !== 32'h0000_0155) begin fails++; $display("FAIL rd_sec: got %h want 00000155", d); end
    @(negedge clk_i);
    checks++; if (prdata_o !== 32'h0) begin fails++; $display("FAIL rd_idle_data: got %h want 0", prdata_o); end
  endtask

  task automatic test_ro_write();
    apb_write(A_TVAL, 32'h0000_1234, 1'b0, rdy, err);
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL tval_wr_err: got %b want 1", err); end
    apb_write(A_DAYCNT, 32'h0000_0005, 1'b0, rdy, err);
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL daycnt_wr_err: got %b want 1", err); end
  endtask

  task automatic test_status_irq();
    apb_write(A_MASK, 32'h1, 1'b0, rdy, err);
    @(posedge clk_i); #1; event_i = 1'b1;
    @(posedge clk_i); #1; event_i = 1'b0;
    checks++; if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_early: got %b want 0", irq_o); end
    @(posedge clk_i); #1;
    checks++; if (irq_o !== 1'b1) begin fails++; $display("FAIL irq_set: got %b want 1", irq_o); end
    apb_read(A_STATUS, rdy0, d0, d, ok);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL status_set: got %h want 1", d); end
    apb_write(A_STATUS, 32'h1, 1'b1, rdy, err);
    apb_read(A_STATUS, rdy0, d0, d, ok);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL status_prio: got %h want 1", d); end
    apb_write(A_STATUS, 32'h1, 1'b0, rdy, err);
    @(posedge clk_i); #1;
    checks++; if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_clear: got %b want 0", irq_o); end
    apb_read(A_STATUS, rdy0, d0, d, ok);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL status_clr: got %h want 0", d); end
    @(posedge clk_i); #1; update_day_i = 1'b1;
    @(posedge clk_i); #1; update_day_i = 1'b0;
    apb_read(A_STATUS, rdy0, d0, d, ok);
    checks++; if (d !== 32'h2) begin fails++; $display("FAIL status_day: got %h want 2", d); end
    checks++; if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_masked: got %b want 0", irq_o); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = A_CLOCK; pwdata_i = 32'h0001_0203;
    @(posedge clk_i); #1; penable_i = 1'b1;
    @(posedge clk_i); #1; penable_i = 1'b0; paddr_i = A_TIMER; pwdata_i = 32'h0000_0111;
    checks++; if (clock_update_o !== 1'b1) begin fails++; $display("FAIL b2b_clk_upd: got %b want 1", clock_update_o); end
    checks++; if (clock_o !== 22'h010203) begin fails++; $display("FAIL b2b_clk_val: got %h want 010203", clock_o); end
    @(posedge clk_i); #1; penable_i = 1'b1;
    checks++; if (clock_update_o !== 1'b0) begin fails++; $display("FAIL b2b_clk_width: got %b want 0", clock_update_o); end
    @(posedge clk_i); #1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    checks++; if (timer_update_o !== 1'b1) begin fails++; $display("FAIL b2b_tmr_upd: got %b want 1", timer_update_o); end
    checks++; if (timer_target_o !== 17'h00111) begin fails++; $display("FAIL b2b_tmr_val: got %h want 00111", timer_target_o); end
    checks++; if (timer_enable_o !== 1'b0) begin fails++; $display("FAIL b2b_tmr_en: got %b want 0", timer_enable_o); end
  endtask

  task automatic test_read_abort();
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = A_TVAL;
    @(posedge clk_i); #1; penable_i = 1'b1; rst_i = 1'b1;
    @(posedge clk_i); #1; rst_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
    @(negedge clk_i);
    checks++; if (pready_o !== 1'b0) begin fails++; $display("FAIL abort_pready: got %b want 0", pready_o); end
    checks++; if (prdata_o !== 32'h0) begin fails++; $display("FAIL abort_prdata: got %h want 0", prdata_o); end
    checks++; if (clock_o !== 22'h0) begin fails++; $display("FAIL abort_clock: got %h want 0", clock_o); end
    checks++; if (timer_target_o !== 17'h0) begin fails++; $display("FAIL abort_ttarget: got %h want 0", timer_target_o); end
  endtask

  task automatic test_daycnt();
    logic [31:0] exp;
`ifdef RTC_DAY_COUNTER_EN
    exp = 32'd3;
`else
    exp = 32'd0;
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1; update_day_i = 1'b1;
      @(posedge clk_i); #1; update_day_i = 1'b0;
    end
    apb_read(A_DAYCNT, rdy0, d0, d, ok);
    checks++; if (!ok) begin fails++; $display("FAIL daycnt_timeout: got 0 want 1"); end
    checks++; if (d !== exp) begin fails++; $display("FAIL daycnt: got %h want %h", d, exp); end
  endtask

  initial begin
    test_reset();
    test_clock_write();
    test_clock_bad();
    test_alarm();
    test_timer_write();
    test_reads();
    test_ro_write();
    test_status_irq();
    test_back_to_back();
    test_read_abort();
    test_daycnt();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
